// File: rtl/pri_enc_sched_pkg.sv
// Shared types and helpers for the pri_enc_sched priority encoder/scheduler.
// Optional feature macro: RR_MODE_EN (round-robin priority instead of fixed).
package pri_enc_sched_pkg;

  // Default number of request lines
  localparam int PRI_N_DEFAULT = 8;

  // Handshake FSM states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  // Index width that never collapses to zero bits
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pri_enc_sched_if.sv
// Request/grant bundle between a request source and pri_enc_sched.
// master = request source / index consumer, slave = the scheduler.
interface pri_enc_sched_if
  import pri_enc_sched_pkg::*;
#(
  parameter int N = PRI_N_DEFAULT
) ();

  localparam int W = idx_width(N);

  logic [N-1:0] I;
  logic         en;
  logic         ack;
  logic [W-1:0] Y;
  logic         out_en;
  logic [N-1:0] pending;
  logic         ovf;

  modport master (
    output I, en, ack,
    input  Y, out_en, pending, ovf
  );

  modport slave (
    input  I, en, ack,
    output Y, out_en, pending, ovf
  );

endinterface

// File: rtl/pri_enc_core.sv
// Combinational finder: first set bit of vec searching downward from start,
// wrapping from bit 0 back to bit N-1.
module pri_enc_core
  import pri_enc_sched_pkg::*;
#(
  parameter  int N = PRI_N_DEFAULT,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  // Walk offsets from farthest to nearest so the position closest to start wins
  always_comb begin
    int start_pos;
    int pos;
    idx       = '0;
    found     = 1'b0;
    start_pos = (int'(start) >= N) ? N - 1 : int'(start);
    pos       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = start_pos - i;
      if (pos < 0) begin
        pos = pos + N;
      end
      if (vec[pos]) begin
        idx   = W'(pos);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pri_enc_sched.sv
// Registered N:log2(N) priority encoder with request capture and grant handshake.
// Define RR_MODE_EN for round-robin priority; default is fixed (bit N-1 highest).
module pri_enc_sched
  import pri_enc_sched_pkg::*;
#(
  parameter int N = PRI_N_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  pri_enc_sched_if.slave   bus
);

  localparam int W = idx_width(N);

  state_e       state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [N-1:0] pending_q, pending_d;
  logic         ovf_q, ovf_d;

  logic [N-1:0] cand;
  logic [N-1:0] grant_mask;
  logic [W-1:0] search_start;
  logic [W-1:0] found_idx;
  logic         found;
  logic         load;

  assign cand = pending_q | bus.I;

  pri_enc_core #(
    .N (N)
  ) u_core (
    .vec   (cand),
    .start (search_start),
    .idx   (found_idx),
    .found (found)
  );

  // A new index is issued when the output slot is free or being freed this cycle
  assign load       = bus.en && found && ((state_q == ST_IDLE) || bus.ack);
  assign grant_mask = load ? (N'(1) << found_idx) : '0;

`ifdef RR_MODE_EN
  logic [W-1:0] ptr_q, ptr_d;

  assign search_start = ptr_q;

  // Next search begins just below the index granted last, wrapping at 0
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = (found_idx == '0) ? W'(N - 1) : found_idx - W'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign search_start = W'(N - 1);
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stall holds VALID, ack either reloads or drops to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (bus.ack) begin
          state_d = load ? ST_VALID : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: granted bit is removed, overlaps on ungranted lines set ovf
  always_comb begin
    y_d       = load ? found_idx : y_q;
    pending_d = cand & ~grant_mask;
    ovf_d     = ovf_q | (|(bus.I & pending_q & ~grant_mask));
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      y_q       <= y_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  // FSM outputs and registered status
  always_comb begin
    bus.out_en  = (state_q == ST_VALID);
    bus.Y       = y_q;
    bus.pending = pending_q;
    bus.ovf     = ovf_q;
  end

endmodule

// File: tb/tb_pri_enc_sched.sv
// Directed bench for pri_enc_sched with N=8 (fixed or RR_MODE_EN build).
module tb_pri_enc_sched;

  logic clk;
  logic rst;
  int   testCount = 0;
  int   failCount = 0;

  pri_enc_sched_if #(.N(8)) bus ();

  pri_enc_sched #(
    .N (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, then move just past the capturing edge
  task automatic applyStimulus(input logic r, input logic [7:0] req,
                               input logic e, input logic a);
    rst     = r;
    bus.I   = req;
    bus.en  = e;
    bus.ack = a;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against hand-computed values
  task automatic checkOutput(input string tag, input logic [2:0] eY,
                             input logic eOe, input logic [7:0] ePend,
                             input logic eOvf);
    testCount++;
    assert (bus.Y === eY) else begin
      failCount++;
      $error("[TB] FAIL %s Y: got %0d expected %0d", tag, bus.Y, eY);
    end
    testCount++;
    assert (bus.out_en === eOe) else begin
      failCount++;
      $error("[TB] FAIL %s out_en: got %b expected %b", tag, bus.out_en, eOe);
    end
    testCount++;
    assert (bus.pending === ePend) else begin
      failCount++;
      $error("[TB] FAIL %s pending: got %h expected %h", tag, bus.pending, ePend);
    end
    testCount++;
    assert (bus.ovf === eOvf) else begin
      failCount++;
      $error("[TB] FAIL %s ovf: got %b expected %b", tag, bus.ovf, eOvf);
    end
  endtask

  initial begin
    logic [2:0] eY;
    logic [7:0] ePend;
    int         seqLen;

    rst     = 1'b1;
    bus.I   = '0;
    bus.en  = 1'b0;
    bus.ack = 1'b0;

    // Power-on reset
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("por", 3'd0, 1'b0, 8'h00, 1'b0);

    // Reset in the middle of a stalled grant
    applyStimulus(1'b0, 8'h21, 1'b1, 1'b0);
    checkOutput("t1_load", 3'd5, 1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("t1_rst1", 3'd0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("t1_rst2", 3'd0, 1'b0, 8'h00, 1'b0);

    // Single request, immediate ack
    applyStimulus(1'b0, 8'h10, 1'b1, 1'b1);
    checkOutput("t2_grant", 3'd4, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("t2_idle", 3'd4, 1'b0, 8'h00, 1'b0);

    // Two requests, consumer stalls three cycles
    applyStimulus(1'b0, 8'h48, 1'b1, 1'b0);
    checkOutput("t3_grant6", 3'd6, 1'b1, 8'h08, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("t3_stall", 3'd6, 1'b1, 8'h08, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("t3_grant3", 3'd3, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("t3_idle", 3'd3, 1'b0, 8'h00, 1'b0);

    // Overflow on a line already pending, sticky until reset
    applyStimulus(1'b0, 8'h10, 1'b0, 1'b0);
    checkOutput("t4_capture", 3'd3, 1'b0, 8'h10, 1'b0);
    applyStimulus(1'b0, 8'h10, 1'b0, 1'b0);
    checkOutput("t4_ovf", 3'd3, 1'b0, 8'h10, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t4_sticky", 3'd3, 1'b0, 8'h10, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("t4_grant4", 3'd4, 1'b1, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("t4_once", 3'd4, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("t4_rst", 3'd0, 1'b0, 8'h00, 1'b0);

    // Capture with en=0, then back-to-back issue
    applyStimulus(1'b0, 8'h81, 1'b0, 1'b0);
    checkOutput("t5_capture", 3'd0, 1'b0, 8'h81, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t5_hold", 3'd0, 1'b0, 8'h81, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("t5_grant7", 3'd7, 1'b1, 8'h01, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("t5_grant0", 3'd0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("t5_idle", 3'd0, 1'b0, 8'h00, 1'b0);

    // Valid index completes on ack even with en=0; pending is kept
    applyStimulus(1'b0, 8'h06, 1'b1, 1'b0);
    checkOutput("t7_grant2", 3'd2, 1'b1, 8'h02, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t7_done", 3'd2, 1'b0, 8'h02, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("t7_rst", 3'd0, 1'b0, 8'h00, 1'b0);

    // All lines held high with continuous ack
`ifdef RR_MODE_EN
    seqLen = 9;
`else
    seqLen = 4;
`endif
    for (int i = 0; i < seqLen; i++) begin
      applyStimulus(1'b0, 8'hFF, 1'b1, 1'b1);
`ifdef RR_MODE_EN
      eY = 3'(7 - (i % 8));
`else
      eY = 3'd7;
`endif
      ePend = 8'hFF & ~(8'h01 << eY);
      checkOutput("t6_allones", eY, 1'b1, ePend, (i != 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
